// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial bit-sequence detector with saturating match counter
module seq_detect_prog #(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 16,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed,
    output logic             cfg_err
);
    localparam logic [LEN_W-1:0] PAT_MAX = LEN_W'(PAT_W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [PAT_W-1:0] hist, hist_n, pat_r, mask;
    logic [LEN_W-1:0] fill, fill_n, len_r;
    logic             ovl_r, cfg_ok, sample, hit;

    always_comb begin
        cfg_ok  = (pat_len != '0) && (pat_len <= PAT_MAX);
        state_n = state;
        if (cfg_load) begin
            state_n = cfg_ok ? RUN : IDLE;
        end
    end

    // fill saturates at PAT_W so fill+1 never needs an extra bit
    always_comb begin
        sample = (state == RUN) && in_valid && !cfg_load;
        hist_n = {hist[PAT_W-2:0], in};
        fill_n = (fill == PAT_MAX) ? fill : fill + LEN_W'(1);
        mask   = {PAT_W{1'b1}} >> (PAT_MAX - len_r);
        hit    = sample && (fill_n >= len_r) && ((hist_n & mask) == (pat_r & mask));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist      <= '0;
            fill      <= '0;
            pat_r     <= '0;
            len_r     <= '0;
            ovl_r     <= 1'b0;
            out       <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            out <= 1'b0;
            if (cfg_load) begin
                hist <= '0;
                fill <= '0;
                if (cfg_ok) begin
                    pat_r     <= pattern;
                    len_r     <= pat_len;
                    ovl_r     <= overlap;
                    match_cnt <= '0;
                    cfg_err   <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (sample) begin
                hist <= hist_n;
                fill <= (hit && !ovl_r) ? '0 : fill_n;
                out  <= hit;
                if (hit && (match_cnt != {CNT_W{1'b1}})) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign armed = (state == RUN);

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - scoreboard bench for seq_detect_prog against a bit-list reference model
module tb_seq_detect_prog;
    localparam int PAT_W = 8;
    localparam int CNT_W = 3;
    localparam int LEN_W = $clog2(PAT_W + 1);

    typedef logic [CNT_W+2:0] vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_bit = 1'b0;
    logic             in_valid = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [LEN_W-1:0] pat_len = '0;
    logic             overlap = 1'b0;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;
    logic             cfg_err;

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in(in_bit), .in_valid(in_valid), .cfg_load(cfg_load),
        .pattern(pattern), .pat_len(pat_len), .overlap(overlap),
        .out(out), .match_cnt(match_cnt), .armed(armed), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    vec_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: the list of bits seen since the last clear, newest at the back
    bit               m_bits[$];
    int               m_cnt = 0;
    bit               m_armed = 0, m_err = 0, m_out = 0, m_ovl = 0;
    int               m_len = 0;
    logic [PAT_W-1:0] m_pat = '0;

    task automatic step(input bit r, input bit b, input bit v, input bit ld,
                        input logic [PAT_W-1:0] p, input int l, input bit o);
        bit matched;
        @(negedge clk);
        rst = r; in_bit = b; in_valid = v; cfg_load = ld;
        pattern = p; pat_len = LEN_W'(l); overlap = o;
        m_out = 0;
        if (!r) begin
            m_bits.delete(); m_cnt = 0; m_armed = 0; m_err = 0;
            m_len = 0; m_pat = '0; m_ovl = 0;
        end else if (ld) begin
            m_bits.delete();
            if (l >= 1 && l <= PAT_W) begin
                m_armed = 1; m_err = 0; m_pat = p; m_len = l; m_ovl = o; m_cnt = 0;
            end else begin
                m_armed = 0; m_err = 1;
            end
        end else if (m_armed && v) begin
            m_bits.push_back(b);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            matched = (m_bits.size() >= m_len);
            for (int i = 0; i < m_len; i++)
                if (matched && m_bits[m_bits.size() - 1 - i] != m_pat[i]) matched = 0;
            if (matched) begin
                m_out = 1;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (!m_ovl) m_bits.delete();
            end
        end
        exp_q.push_back({m_out, CNT_W'(m_cnt), m_armed, m_err});
    endtask

    task automatic stream(input logic [31:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            step(1, bits[i], 1, 0, '0, 0, 0);
            for (int g = 0; g < gap; g++) step(1, $urandom_range(0, 1), 0, 0, '0, 0, 0);
        end
    endtask

    task automatic cfg(input logic [PAT_W-1:0] p, input int l, input bit o);
        step(1, 0, 1, 1, p, l, o);
    endtask

    initial begin : monitor
        vec_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {out, match_cnt, armed, cfg_err};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t: got out=%0b cnt=%0d armed=%0b err=%0b, want out=%0b cnt=%0d armed=%0b err=%0b",
                             $time, a[CNT_W+2], a[CNT_W+1:2], a[1], a[0],
                             e[CNT_W+2], e[CNT_W+1:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin : driver
        int r, l;
        repeat (2) step(0, 0, 0, 0, '0, 0, 0);
        step(1, 1, 1, 0, '0, 0, 0);
        // overlapping and non-overlapping 11011 on 11011011
        cfg(8'b11011, 5, 1);  stream(32'b11011011, 8, 0);
        cfg(8'b11011, 5, 0);  stream(32'b11011011, 8, 0);
        // 101 spread over in_valid gaps
        cfg(8'b101, 3, 1);    stream(32'b101, 3, 2);
        // illegal lengths, then legal
        step(0, 0, 0, 0, '0, 0, 0);
        cfg(8'b1, 0, 1);      stream(32'hFFFF_FFFF, 6, 0);
        cfg(8'b1, 9, 1);      stream(32'h0, 3, 0);
        cfg(8'b1, 1, 1);      stream(32'hFFFF_FFFF, 10, 0);
        // full-width pattern
        cfg(8'hA5, 8, 1);     stream(32'hA5A5, 16, 1);
        // reset mid-pattern, then stream with no reload
        cfg(8'b10110, 5, 1);  stream(32'b1011, 4, 0);
        step(0, 0, 1, 0, '0, 0, 0);
        stream(32'b10110101, 8, 0);
        cfg(8'b10110, 5, 1);  stream(32'b0110, 4, 0);
        cfg(8'b11, 2, 0);     stream(32'b0110, 4, 0);
        // randomized traffic
        cfg(8'b1, 2, 1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                step(0, 0, 0, 0, '0, 0, 0);
            end else if ($urandom_range(0, 59) == 0) begin
                r = $urandom_range(0, 19);
                l = (r == 0) ? 0 : (r == 1) ? $urandom_range(9, 15) :
                    (r == 2) ? PAT_W : $urandom_range(1, 4);
                cfg(PAT_W'($urandom), l, $urandom_range(0, 1));
            end else begin
                step(1, $urandom_range(0, 1), $urandom_range(0, 3) != 0, 0,
                     PAT_W'($urandom), $urandom_range(0, 15), $urandom_range(0, 1));
            end
        end
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never compared, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
